// File: rtl/clock_set_controller.sv
// clock_set_controller: button debounce, RUN/SET_* sequencer, adjust pulses with
// auto-repeat, run enable and digit-blink masks for the HH:MM:SS datapath.
`timescale 1ns/1ps
module clock_set_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY    = 25_000_000,
    parameter int unsigned REPEAT_RATE     = 10_000_000,
    parameter int unsigned BLINK_CYCLES    = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode_btn_n,
    input  logic       inc_btn_n,
    input  logic       hold_sw,
    output logic       run_en,
    output logic       presc_clr,
    output logic       hr_inc,
    output logic       min_inc,
    output logic       sec_clr,
    output logic [2:0] blink_mask,
    output logic [1:0] mode
);

    localparam int unsigned maxAB  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int unsigned maxCD  = (REPEAT_RATE > BLINK_CYCLES) ? REPEAT_RATE : BLINK_CYCLES;
    localparam int unsigned cntMax = (maxAB > maxCD) ? maxAB : maxCD;
    localparam int unsigned cntW   = $clog2(cntMax + 1);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10,
        SET_SEC = 2'b11
    } state_t;

    state_t            state, stateNext;

    // index 0 = mode button, index 1 = inc button
    logic [1:0]        btnRaw, sync1, sync2, debLvl, pressEvt;
    logic [cntW-1:0]   dbCnt [2];

    logic              modeEvt, incEvt, incHeld;

    logic              repActive, repFirst;
    logic [cntW-1:0]   repCnt;

    logic [cntW-1:0]   blinkCnt, blinkCntNext;
    logic              phaseOff, phaseOffNext;
    logic [2:0]        maskNext;

    assign btnRaw  = {inc_btn_n, mode_btn_n};
    assign modeEvt = pressEvt[0];
    assign incEvt  = pressEvt[1];
    assign incHeld = ~debLvl[1];
    assign mode    = state;

    // Synchronize both buttons and accept a new level after DEBOUNCE_CYCLES equal samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= '1;
            sync2    <= '1;
            debLvl   <= '1;
            pressEvt <= '0;
            for (int unsigned i = 0; i < 2; i++) dbCnt[i] <= '0;
        end else begin
            sync1 <= btnRaw;
            sync2 <= sync1;
            for (int unsigned i = 0; i < 2; i++) begin
                pressEvt[i] <= 1'b0;
                if (sync2[i] == debLvl[i]) begin
                    dbCnt[i] <= '0;
                end else if (dbCnt[i] == cntW'(DEBOUNCE_CYCLES - 1)) begin
                    dbCnt[i]    <= '0;
                    debLvl[i]   <= sync2[i];
                    pressEvt[i] <= ~sync2[i];
                end else begin
                    dbCnt[i] <= dbCnt[i] + cntW'(1);
                end
            end
        end
    end

    // Next state and next blink phase, so registered outputs line up with the mode output
    always_comb begin
        stateNext    = state;
        blinkCntNext = blinkCnt;
        phaseOffNext = phaseOff;
        maskNext     = 3'b000;
        if (modeEvt) begin
            case (state)
                RUN:     stateNext = SET_HR;
                SET_HR:  stateNext = SET_MIN;
                SET_MIN: stateNext = SET_SEC;
                default: stateNext = RUN;
            endcase
            blinkCntNext = '0;
            phaseOffNext = 1'b0;
        end else if (blinkCnt == cntW'(BLINK_CYCLES - 1)) begin
            blinkCntNext = '0;
            phaseOffNext = ~phaseOff;
        end else begin
            blinkCntNext = blinkCnt + cntW'(1);
        end
        case (stateNext)
            SET_HR:  maskNext = {phaseOffNext, 2'b00};
            SET_MIN: maskNext = {1'b0, phaseOffNext, 1'b0};
            SET_SEC: maskNext = {2'b00, phaseOffNext};
            default: maskNext = 3'b000;
        endcase
    end

    // Sequencer: mode transitions, adjust pulses with auto-repeat, run enable, blink
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            run_en     <= 1'b0;
            presc_clr  <= 1'b0;
            hr_inc     <= 1'b0;
            min_inc    <= 1'b0;
            sec_clr    <= 1'b0;
            blink_mask <= '0;
            repActive  <= 1'b0;
            repFirst   <= 1'b0;
            repCnt     <= '0;
            blinkCnt   <= '0;
            phaseOff   <= 1'b0;
        end else begin
            state      <= stateNext;
            run_en     <= (stateNext == RUN) && !hold_sw;
            blink_mask <= maskNext;
            blinkCnt   <= blinkCntNext;
            phaseOff   <= phaseOffNext;
            presc_clr  <= 1'b0;
            hr_inc     <= 1'b0;
            min_inc    <= 1'b0;
            sec_clr    <= 1'b0;
            // mode press has priority; a coincident inc press or repeat pulse is dropped
            if (modeEvt) begin
                presc_clr <= (state == SET_SEC);
                repActive <= 1'b0;
                repFirst  <= 1'b0;
                repCnt    <= '0;
            end else if (incEvt) begin
                case (state)
                    SET_HR: begin
                        hr_inc    <= 1'b1;
                        repActive <= 1'b1;
                        repFirst  <= 1'b1;
                        repCnt    <= cntW'(1);
                    end
                    SET_MIN: begin
                        min_inc   <= 1'b1;
                        repActive <= 1'b1;
                        repFirst  <= 1'b1;
                        repCnt    <= cntW'(1);
                    end
                    SET_SEC: sec_clr <= 1'b1;
                    default: ;
                endcase
            end else if (repActive) begin
                if (!incHeld) begin
                    repActive <= 1'b0;
                    repFirst  <= 1'b0;
                    repCnt    <= '0;
                end else if ((repFirst && repCnt == cntW'(REPEAT_DELAY)) ||
                             (!repFirst && repCnt == cntW'(REPEAT_RATE))) begin
                    hr_inc   <= (state == SET_HR);
                    min_inc  <= (state == SET_MIN);
                    repFirst <= 1'b0;
                    repCnt   <= cntW'(1);
                end else begin
                    repCnt <= repCnt + cntW'(1);
                end
            end
        end
    end

endmodule
